// File: rtl/bin_to_bcd_serial_if.sv
// Purpose : start/done handshake and result bus of the serial binary-to-BCD converter.
// Latency : n/a (signal bundle only).
// Backpressure: none; the converter ignores i_start while o_busy is high.
// Ports   : i_start/i_bin (requester -> converter), o_busy/o_done/o_bcd/o_overflow (converter -> requester).
//   master modport = requester side, slave modport = converter side.
//   BIN_W/DIGITS must match the parameters of the converter this bundle is connected to.
interface bin_to_bcd_serial_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_overflow;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_bcd, o_overflow
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_bcd, o_overflow
  );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Purpose : sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Latency : start accepted at edge 0 -> o_done pulses in the cycle after edge BIN_W+1.
// Backpressure: i_start ignored while o_busy=1; a start held during the DONE cycle is taken with no gap.
// Ports   : i_clk, i_rst (async, active-high); bus = slave modport of bin_to_bcd_serial_if
//   (i_start, i_bin in; o_busy, o_done, o_bcd, o_overflow out, all registered).
//   Digit k of o_bcd sits at [4k+3:4k]; o_bcd saturates to all 9s on overflow.
module bin_to_bcd_serial #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  bin_to_bcd_serial_if.slave    bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [BIN_W-1:0] r_bin;      // captured input, consumed MSB first
  logic [BCD_W-1:0] r_bcd;      // scratch BCD digits
  logic [CNT_W-1:0] r_cnt;      // shifts remaining
  logic             r_ovf;      // sticky: a 1 fell off the top digit
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_bcd_out;
  logic             r_ovf_out;

  logic [BCD_W-1:0] w_adj;      // scratch digits after the add-3 step

  // Each digit is adjusted on its own 4 bits; a valid digit (0..9) never
  // produces a carry here, so no inter-digit carry chain is needed.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state <= S_SHIFT;
            r_bin   <= bus.i_bin;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_W'(BIN_W);
            r_busy  <= 1'b1;
          end
        end

        S_SHIFT: begin
          // {bcd,bin} shifted left by one after the adjust step.
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= r_bin << 1;
          r_ovf <= r_ovf | w_adj[BCD_W-1];
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end
        end

        S_DONE: begin
          // Publish the finished scratch result; a new start in this same
          // cycle only touches the scratch registers, so both can happen.
          r_done    <= 1'b1;
          r_bcd_out <= r_ovf ? {DIGITS{4'h9}} : r_bcd;
          r_ovf_out <= r_ovf;
          if (bus.i_start) begin
            r_state <= S_SHIFT;
            r_bin   <= bus.i_bin;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_W'(BIN_W);
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_bcd      = r_bcd_out;
  assign bus.o_overflow = r_ovf_out;
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Purpose : bench for bin_to_bcd_serial; a 5-digit and a 4-digit instance share the same stimulus.
// Latency : model expects o_done in the cycle after edge BIN_W+1 following an accepted start.
// Backpressure: model ignores starts that land while the converter is shifting.
module tb_bin_to_bcd_serial;
  localparam int BIN_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  bit          chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  bin_to_bcd_serial_if #(.BIN_W(BIN_W), .DIGITS(5)) if5 ();
  bin_to_bcd_serial_if #(.BIN_W(BIN_W), .DIGITS(4)) if4 ();

  assign if5.i_start = start;
  assign if5.i_bin   = bin;
  assign if4.i_start = start;
  assign if4.i_bin   = bin;

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(5)) u_dut5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if5.slave)
  );

  bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(4)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if4.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal conversion by plain arithmetic, saturating when out of range.
  task automatic ref_bcd(input int v, input int d, output logic [19:0] bcd, output logic ovf);
    int lim;
    int x;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    bcd = '0;
    if (v >= lim) begin
      ovf = 1'b1;
      for (int i = 0; i < d; i++) bcd[4*i +: 4] = 4'h9;
    end else begin
      ovf = 1'b0;
      x = v;
      for (int i = 0; i < d; i++) begin
        bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endtask

  // Cycle-level expectation built from accept times, not from converter internals.
  int          edge_n   = 0;
  int          acc_edge = 0;
  bit          acc_vld  = 1'b0;
  logic [15:0] pend_v   = '0;
  logic        m_busy   = 1'b0;
  logic        m_done   = 1'b0;
  logic [19:0] m_bcd5   = '0;
  logic        m_ovf5   = 1'b0;
  logic [19:0] m_bcd4   = '0;
  logic        m_ovf4   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_vld = 1'b0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_bcd5  = '0;
      m_ovf5  = 1'b0;
      m_bcd4  = '0;
      m_ovf4  = 1'b0;
    end else begin
      edge_n++;
      m_done = acc_vld && (edge_n == acc_edge + BIN_W + 1);
      if (m_done) begin
        ref_bcd(int'(pend_v), 5, m_bcd5, m_ovf5);
        ref_bcd(int'(pend_v), 4, m_bcd4, m_ovf4);
      end
      if (start && !(acc_vld && edge_n >= acc_edge + 1 && edge_n <= acc_edge + BIN_W)) begin
        acc_vld  = 1'b1;
        acc_edge = edge_n;
        pend_v   = bin;
      end
      m_busy = acc_vld && edge_n >= acc_edge && edge_n <= acc_edge + BIN_W - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy5", 32'(if5.o_busy), 32'(m_busy));
      chk("done5", 32'(if5.o_done), 32'(m_done));
      chk("bcd5",  32'(if5.o_bcd), 32'(m_bcd5));
      chk("ovf5",  32'(if5.o_overflow), 32'(m_ovf5));
      chk("busy4", 32'(if4.o_busy), 32'(m_busy));
      chk("done4", 32'(if4.o_done), 32'(m_done));
      chk("bcd4",  32'(if4.o_bcd), 32'(m_bcd4));
      chk("ovf4",  32'(if4.o_overflow), 32'(m_ovf4));
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(if5.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(if5.o_done), 32'd0);
    chk({tag, "_bcd5"}, 32'(if5.o_bcd), 32'd0);
    chk({tag, "_ovf5"}, 32'(if5.o_overflow), 32'd0);
    chk({tag, "_bcd4"}, 32'(if4.o_bcd), 32'd0);
    chk({tag, "_ovf4"}, 32'(if4.o_overflow), 32'd0);
  endtask

  // One isolated conversion; i_bin is scrambled while busy.
  task automatic do_conv(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    repeat (BIN_W + 3) @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst    = 1'b0;
    chk_en = 1'b1;

    do_conv(16'd0);
    chk("t1_bcd", 32'(if5.o_bcd), 32'h00000);

    do_conv(16'd1234);
    chk("t2_bcd", 32'(if5.o_bcd), 32'h01234);

    // Start held through the DONE cycle chains straight into the next one.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd65535;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'h1111;
    repeat (BIN_W) @(negedge clk);
    start = 1'b1;
    bin   = 16'd7;
    @(negedge clk);
    chk("t3_bcd_a", 32'(if5.o_bcd), 32'h65535);
    chk("t3_chain_busy", 32'(if5.o_busy), 32'd1);
    start = 1'b0;
    repeat (BIN_W + 2) @(negedge clk);
    chk("t3_bcd_b", 32'(if5.o_bcd), 32'h00007);

    do_conv(16'd12345);
    chk("t4_bcd4", 32'(if4.o_bcd), 32'h9999);
    chk("t4_ovf4", 32'(if4.o_overflow), 32'd1);
    do_conv(16'd9999);
    chk("t4_bcd4b", 32'(if4.o_bcd), 32'h9999);
    chk("t4_ovf4b", 32'(if4.o_overflow), 32'd0);

    // Start pulsed mid-conversion must be ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (BIN_W + 2) @(negedge clk);
    chk("t5_bcd", 32'(if5.o_bcd), 32'h00500);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd777;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (BIN_W + 3) @(negedge clk);
    chk("t6_nodone_bcd", 32'(if5.o_bcd), 32'd0);
    do_conv(16'd4321);
    chk("t6_bcd", 32'(if5.o_bcd), 32'h04321);

    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) do_conv(16'($urandom_range(0, 9999)));
      else            do_conv(16'($urandom));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
